// File: rtl/vc_allocator.sv
// Virtual-channel allocator: keeps the VC busy mask, grants free VCs round-robin,
// and returns VCs to the pool from {valid, one-hot VC} release words.
module vc_allocator #(
    parameter int NUM_VC = 7,
    parameter int CW     = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alloc_req,
    output logic              alloc_gnt,
    output logic [NUM_VC-1:0] alloc_vc,
    input  logic [NUM_VC:0]   release_in,
    output logic [NUM_VC-1:0] busy_mask,
    output logic [CW-1:0]     free_cnt,
    output logic              all_busy,
    output logic              err_release
);

    localparam int             PW    = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;
    localparam logic [PW:0]    L_NVC = (PW+1)'(NUM_VC);
    localparam logic [PW-1:0]  L_TOP = PW'(NUM_VC - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_GRANT
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [NUM_VC-1:0] r_busy;
    logic [CW-1:0]     r_free_cnt;
    logic              r_all_busy;
    logic              r_gnt;
    logic [NUM_VC-1:0] r_vc;
    logic              r_err;
    logic [PW-1:0]     r_rr_ptr;

    logic [PW-1:0]     w_cand [NUM_VC];
    logic [NUM_VC-1:0] w_win_oh;
    logic [PW-1:0]     w_win;
    logic [PW-1:0]     w_rr_next;
    logic              w_found;
    logic              w_alloc;
    logic              w_rel_valid;
    logic [NUM_VC-1:0] w_payload;
    logic              w_onehot;
    logic              w_rel_ok;
    logic              w_rel_err;
    logic [NUM_VC-1:0] w_clear;
    logic [NUM_VC-1:0] w_set;
    logic [NUM_VC-1:0] w_busy_next;
    logic [CW-1:0]     w_free_cnt_next;

    // Candidate k of the search is (rr_ptr + k) mod NUM_VC.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_VC; gi++) begin : g_cand
            logic [PW:0] w_sum;
            assign w_sum       = {1'b0, r_rr_ptr} + (PW+1)'(gi);
            assign w_cand[gi]  = (w_sum >= L_NVC) ? PW'(w_sum - L_NVC) : w_sum[PW-1:0];
            assign w_win_oh[gi] = (w_win == PW'(gi));
        end
    endgenerate

    // Walk from the farthest candidate down so the nearest free VC wins last.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int k = NUM_VC - 1; k >= 0; k--) begin
            if (!r_busy[w_cand[k]]) begin
                w_found = 1'b1;
                w_win   = w_cand[k];
            end
        end
    end

    assign w_rr_next = (w_win == L_TOP) ? '0 : w_win + PW'(1);

    assign w_rel_valid = release_in[NUM_VC];
    assign w_payload   = release_in[NUM_VC-1:0];
    assign w_onehot    = (w_payload != '0) &&
                         ((w_payload & (w_payload - NUM_VC'(1))) == '0);
    assign w_rel_ok    = w_rel_valid && w_onehot && ((w_payload & r_busy) != '0);
    assign w_rel_err   = w_rel_valid && !w_rel_ok;
    assign w_clear     = w_rel_ok ? w_payload : '0;

    always_comb begin
        w_state_next = r_state;
        w_alloc      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (alloc_req) begin
                    if (w_found) begin
                        w_state_next = S_GRANT;
                        w_alloc      = 1'b1;
                    end else begin
                        w_state_next = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (!alloc_req) begin
                    w_state_next = S_IDLE;
                end else if (w_found) begin
                    w_state_next = S_GRANT;
                    w_alloc      = 1'b1;
                end
            end
            S_GRANT: w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Set only touches a free bit and clear only a busy bit, so both can apply together.
    assign w_set       = w_alloc ? w_win_oh : '0;
    assign w_busy_next = (r_busy | w_set) & ~w_clear;

    always_comb begin
        w_free_cnt_next = '0;
        for (int i = 0; i < NUM_VC; i++) begin
            if (!w_busy_next[i]) begin
                w_free_cnt_next = w_free_cnt_next + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_busy     <= '0;
            r_free_cnt <= CW'(NUM_VC);
            r_all_busy <= 1'b0;
            r_gnt      <= 1'b0;
            r_vc       <= '0;
            r_err      <= 1'b0;
            r_rr_ptr   <= '0;
        end else begin
            r_state    <= w_state_next;
            r_busy     <= w_busy_next;
            r_free_cnt <= w_free_cnt_next;
            r_all_busy <= &w_busy_next;
            r_gnt      <= w_alloc;
            r_vc       <= w_set;
            r_err      <= w_rel_err;
            if (w_alloc) begin
                r_rr_ptr <= w_rr_next;
            end
        end
    end

    assign alloc_gnt   = r_gnt;
    assign alloc_vc    = r_vc;
    assign busy_mask   = r_busy;
    assign free_cnt    = r_free_cnt;
    assign all_busy    = r_all_busy;
    assign err_release = r_err;

endmodule

// File: tb/tb_vc_allocator.sv
// Directed bench for vc_allocator: reset, round-robin, release, illegal releases,
// wrap-around, reset mid-grant and simultaneous alloc/release.
module tb_vc_allocator;

    logic       clk;
    logic       rst_n;
    logic       alloc_req;
    logic       alloc_gnt;
    logic [6:0] alloc_vc;
    logic [7:0] release_in;
    logic [6:0] busy_mask;
    logic [2:0] free_cnt;
    logic       all_busy;
    logic       err_release;

    int checks = 0;
    int errors = 0;

    vc_allocator #(.NUM_VC(7), .CW(3)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .alloc_req   (alloc_req),
        .alloc_gnt   (alloc_gnt),
        .alloc_vc    (alloc_vc),
        .release_in  (release_in),
        .busy_mask   (busy_mask),
        .free_cnt    (free_cnt),
        .all_busy    (all_busy),
        .err_release (err_release)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; alloc_req = 1'b0; release_in = 8'h00;
        tick(); tick();
        checks++; if (busy_mask !== 7'h00) begin errors++; $display("FAIL reset_busy: got %h want 00", busy_mask); end
        checks++; if (free_cnt !== 3'd7) begin errors++; $display("FAIL reset_free_cnt: got %0d want 7", free_cnt); end
        checks++; if (alloc_gnt !== 1'b0 || alloc_vc !== 7'h00) begin errors++; $display("FAIL reset_gnt: got gnt=%b vc=%h want 0/00", alloc_gnt, alloc_vc); end
        checks++; if (err_release !== 1'b0 || all_busy !== 1'b0) begin errors++; $display("FAIL reset_flags: got err=%b all_busy=%b want 0/0", err_release, all_busy); end
        rst_n = 1'b1;
        $display("reset done: busy=%h free=%0d", busy_mask, free_cnt);
    endtask

    task automatic test_round_robin();
        logic [6:0] exp_vc;
        logic [6:0] exp_busy;
        for (int i = 0; i < 7; i++) begin
            exp_vc   = 7'h01 << i;
            exp_busy = 7'h7F >> (6 - i);
            alloc_req = 1'b1;
            tick();
            $display("rr grant %0d: gnt=%b vc=%h busy=%h", i, alloc_gnt, alloc_vc, busy_mask);
            checks++; if (alloc_gnt !== 1'b1 || alloc_vc !== exp_vc) begin errors++; $display("FAIL rr_grant%0d: got gnt=%b vc=%h want 1/%h", i, alloc_gnt, alloc_vc, exp_vc); end
            checks++; if (busy_mask !== exp_busy) begin errors++; $display("FAIL rr_busy%0d: got %h want %h", i, busy_mask, exp_busy); end
            alloc_req = 1'b0;
            tick();
            checks++; if (alloc_gnt !== 1'b0 || alloc_vc !== 7'h00) begin errors++; $display("FAIL rr_pulse%0d: got gnt=%b vc=%h want 0/00", i, alloc_gnt, alloc_vc); end
        end
        alloc_req = 1'b1;
        tick();
        $display("rr 8th request: gnt=%b all_busy=%b free=%0d", alloc_gnt, all_busy, free_cnt);
        checks++; if (alloc_gnt !== 1'b0) begin errors++; $display("FAIL rr_wait_gnt: got %b want 0", alloc_gnt); end
        checks++; if (all_busy !== 1'b1 || free_cnt !== 3'd0) begin errors++; $display("FAIL rr_full: got all_busy=%b free=%0d want 1/0", all_busy, free_cnt); end
    endtask

    task automatic test_release();
        release_in = 8'h84;
        tick();
        release_in = 8'h00;
        $display("release 84: busy=%h free=%0d gnt=%b", busy_mask, free_cnt, alloc_gnt);
        checks++; if (busy_mask !== 7'h7B || free_cnt !== 3'd1) begin errors++; $display("FAIL rel_clear: got busy=%h free=%0d want 7b/1", busy_mask, free_cnt); end
        checks++; if (alloc_gnt !== 1'b0 || all_busy !== 1'b0) begin errors++; $display("FAIL rel_no_early_gnt: got gnt=%b all_busy=%b want 0/0", alloc_gnt, all_busy); end
        tick();
        $display("release grant: gnt=%b vc=%h busy=%h", alloc_gnt, alloc_vc, busy_mask);
        checks++; if (alloc_gnt !== 1'b1 || alloc_vc !== 7'h04) begin errors++; $display("FAIL rel_grant: got gnt=%b vc=%h want 1/04", alloc_gnt, alloc_vc); end
        checks++; if (busy_mask !== 7'h7F || free_cnt !== 3'd0) begin errors++; $display("FAIL rel_refill: got busy=%h free=%0d want 7f/0", busy_mask, free_cnt); end
        alloc_req = 1'b0;
        tick();
    endtask

    task automatic test_illegal_release();
        logic [7:0] words [3] = '{8'h86, 8'h80, 8'h86};
        for (int i = 0; i < 2; i++) begin
            release_in = words[i];
            tick();
            $display("illegal %h: err=%b busy=%h", words[i], err_release, busy_mask);
            checks++; if (err_release !== 1'b1) begin errors++; $display("FAIL ill_err_%h: got %b want 1", words[i], err_release); end
            checks++; if (busy_mask !== 7'h7F) begin errors++; $display("FAIL ill_busy_%h: got %h want 7f", words[i], busy_mask); end
            release_in = 8'h00;
            tick();
            checks++; if (err_release !== 1'b0) begin errors++; $display("FAIL ill_pulse_%h: got %b want 0", words[i], err_release); end
        end
        release_in = 8'h81;
        tick();
        checks++; if (err_release !== 1'b0 || busy_mask !== 7'h7E) begin errors++; $display("FAIL legal_81: got err=%b busy=%h want 0/7e", err_release, busy_mask); end
        tick();
        $display("release 81 on free VC0: err=%b busy=%h", err_release, busy_mask);
        checks++; if (err_release !== 1'b1 || busy_mask !== 7'h7E) begin errors++; $display("FAIL ill_free_81: got err=%b busy=%h want 1/7e", err_release, busy_mask); end
        release_in = 8'h04;
        tick();
        release_in = 8'h00;
        $display("release 04 (invalid): err=%b busy=%h", err_release, busy_mask);
        checks++; if (err_release !== 1'b0 || busy_mask !== 7'h7E) begin errors++; $display("FAIL novalid_04: got err=%b busy=%h want 0/7e", err_release, busy_mask); end
    endtask

    task automatic test_wraparound();
        logic [7:0] rel [3]  = '{8'h88, 8'h90, 8'hA0};
        logic [6:0] expv [4] = '{7'h08, 7'h10, 7'h20, 7'h01};
        for (int i = 0; i < 3; i++) begin
            release_in = rel[i];
            tick();
        end
        release_in = 8'h00;
        checks++; if (busy_mask !== 7'h46 || free_cnt !== 3'd4) begin errors++; $display("FAIL wrap_setup: got busy=%h free=%0d want 46/4", busy_mask, free_cnt); end
        for (int i = 0; i < 4; i++) begin
            alloc_req = 1'b1;
            tick();
            $display("wrap grant %0d: gnt=%b vc=%h", i, alloc_gnt, alloc_vc);
            checks++; if (alloc_gnt !== 1'b1 || alloc_vc !== expv[i]) begin errors++; $display("FAIL wrap_grant%0d: got gnt=%b vc=%h want 1/%h", i, alloc_gnt, alloc_vc, expv[i]); end
            alloc_req = 1'b0;
            tick();
        end
        checks++; if (busy_mask !== 7'h7F || all_busy !== 1'b1) begin errors++; $display("FAIL wrap_full: got busy=%h all_busy=%b want 7f/1", busy_mask, all_busy); end
    endtask

    task automatic test_reset_mid_grant();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            alloc_req = 1'b1;
            tick();
            if (i < 5) begin
                alloc_req = 1'b0;
                tick();
            end
        end
        checks++; if (alloc_gnt !== 1'b1 || busy_mask !== 7'h3F || alloc_vc !== 7'h20) begin errors++; $display("FAIL mid_setup: got gnt=%b busy=%h vc=%h want 1/3f/20", alloc_gnt, busy_mask, alloc_vc); end
        rst_n = 1'b0; alloc_req = 1'b0;
        tick();
        $display("reset in grant: gnt=%b busy=%h", alloc_gnt, busy_mask);
        checks++; if (alloc_gnt !== 1'b0 || alloc_vc !== 7'h00) begin errors++; $display("FAIL mid_gnt: got gnt=%b vc=%h want 0/00", alloc_gnt, alloc_vc); end
        checks++; if (busy_mask !== 7'h00 || free_cnt !== 3'd7) begin errors++; $display("FAIL mid_busy: got busy=%h free=%0d want 00/7", busy_mask, free_cnt); end
        rst_n = 1'b1; alloc_req = 1'b1;
        tick();
        $display("post-reset grant: gnt=%b vc=%h", alloc_gnt, alloc_vc);
        checks++; if (alloc_gnt !== 1'b1 || alloc_vc !== 7'h01) begin errors++; $display("FAIL mid_post: got gnt=%b vc=%h want 1/01", alloc_gnt, alloc_vc); end
        alloc_req = 1'b0;
        tick();
    endtask

    // A VC freed on the allocation edge must not be picked on that edge.
    task automatic test_simultaneous();
        for (int i = 1; i < 7; i++) begin
            alloc_req = 1'b1;
            tick();
            alloc_req = 1'b0;
            tick();
        end
        checks++; if (busy_mask !== 7'h7F) begin errors++; $display("FAIL sim_setup: got %h want 7f", busy_mask); end
        release_in = 8'h88;
        tick();
        alloc_req = 1'b1; release_in = 8'h81;
        tick();
        alloc_req = 1'b0; release_in = 8'h00;
        $display("simultaneous: gnt=%b vc=%h busy=%h", alloc_gnt, alloc_vc, busy_mask);
        checks++; if (alloc_gnt !== 1'b1 || alloc_vc !== 7'h08) begin errors++; $display("FAIL sim_grant: got gnt=%b vc=%h want 1/08", alloc_gnt, alloc_vc); end
        checks++; if (busy_mask !== 7'h7E || err_release !== 1'b0 || free_cnt !== 3'd1) begin errors++; $display("FAIL sim_busy: got busy=%h err=%b free=%0d want 7e/0/1", busy_mask, err_release, free_cnt); end
        tick();
    endtask

    initial begin
        rst_n = 1'b0; alloc_req = 1'b0; release_in = 8'h00;
        test_reset();
        test_round_robin();
        test_release();
        test_illegal_release();
        test_wraparound();
        test_reset_mid_grant();
        test_simultaneous();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
